// File: rtl/rsff_bank_sched_pkg.sv
// rsff_bank_sched_pkg: shared op and FSM state encodings for the flag bank scheduler.
package rsff_bank_sched_pkg;
  typedef enum logic [1:0] {OP_READ = 2'b00, OP_SET = 2'b01, OP_CLR = 2'b10, OP_TGL = 2'b11} op_e;
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_APPLY = 2'b01, S_DONE = 2'b10} state_e;
endpackage

// File: rtl/rsff_bank_sched_rr_arbiter.sv
// rsff_bank_sched_rr_arbiter: combinational round-robin pick, ptr has top priority.
module rsff_bank_sched_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [PW-1:0]   win,
  output logic            valid
);
  // Lowest requester overall, then overridden by the lowest at or above ptr.
  always_comb begin
    win = '0;
    for (int i = NREQ - 1; i >= 0; i--) win = req[i] ? PW'(i) : win;
    for (int i = NREQ - 1; i >= 0; i--) win = (req[i] && PW'(i) >= ptr) ? PW'(i) : win;
    valid = |req;
    onehot = valid ? (NREQ'(1) << win) : '0;
  end
endmodule

// File: rtl/rsff_bank_sched.sv
// rsff_bank_sched: round-robin scheduler granting one requester at a time access to a shared flag bank.
module rsff_bank_sched
  import rsff_bank_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int NFLAG = 8,
  parameter int IDXW = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    op,
  input  logic [IDXW*NREQ-1:0] idx,
  input  logic                 set_all,
  output logic [NREQ-1:0]      gnt,
  output logic                 ack,
  output logic                 rdata,
  output logic                 err,
  output logic [NFLAG-1:0]     flags,
  output logic                 busy
);
  localparam int PW = $clog2(NREQ);
  state_e state, state_nx;
  logic [PW-1:0] rr_ptr, win, arb_win;
  logic [NREQ-1:0] arb_onehot;
  logic arb_valid, req_win, hit, old_bit;
  logic [1:0] lat_op, sel_op;
  logic [IDXW-1:0] lat_idx, sel_idx;
  logic [NFLAG-1:0] nxt;
  rsff_bank_sched_rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr_arbiter (
    .req(req), .ptr(rr_ptr), .onehot(arb_onehot), .win(arb_win), .valid(arb_valid)
  );
  always_comb begin
    sel_op = '0;
    sel_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_op = (arb_win == PW'(i)) ? op[2*i +: 2] : sel_op;
      sel_idx = (arb_win == PW'(i)) ? idx[IDXW*i +: IDXW] : sel_idx;
    end
  end
  // An index with no matching flag leaves hit low, which is the error case.
  always_comb begin
    hit = 1'b0;
    old_bit = 1'b0;
    nxt = flags;
    for (int f = 0; f < NFLAG; f++) begin
      if (lat_idx == IDXW'(f)) begin
        hit = 1'b1;
        old_bit = flags[f];
        nxt[f] = (lat_op == OP_SET) ? 1'b1 : (lat_op == OP_CLR) ? 1'b0 :
                 (lat_op == OP_TGL) ? ~flags[f] : flags[f];
      end
    end
  end
  assign req_win = |(req & gnt);
  always_comb begin
    state_nx = state;
    state_nx = (state == S_IDLE) ? (arb_valid ? S_APPLY : S_IDLE) :
               (state == S_APPLY) ? S_DONE : (req_win ? S_DONE : S_IDLE);
  end
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      gnt <= '0;
      ack <= 1'b0;
      rdata <= 1'b0;
      err <= 1'b0;
      flags <= '0;
      rr_ptr <= '0;
      win <= '0;
      lat_op <= '0;
      lat_idx <= '0;
    end else begin
      state <= state_nx;
      flags <= set_all ? '1 : (state == S_APPLY) ? nxt : flags;
      if (state == S_IDLE && arb_valid) begin
        gnt <= arb_onehot;
        win <= arb_win;
        lat_op <= sel_op;
        lat_idx <= sel_idx;
      end
      if (state == S_APPLY) begin
        ack <= 1'b1;
        rdata <= old_bit;
        err <= ~hit;
        rr_ptr <= (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
      end
      if (state == S_DONE && !req_win) begin
        gnt <= '0;
        ack <= 1'b0;
        err <= 1'b0;
      end
    end
  end
  assign busy = (state != S_IDLE);
endmodule

// File: tb/tb_rsff_bank_sched.sv
// tb_rsff_bank_sched: directed scenario tests for the flag bank scheduler (NREQ=4, NFLAG=6).
module tb_rsff_bank_sched;
  logic clk = 1'b1;
  logic reset = 1'b0;
  logic [3:0] req = '0;
  logic [7:0] op = '0;
  logic [11:0] idx = '0;
  logic set_all = 1'b0;
  logic [3:0] gnt;
  logic ack, rdata, err, busy;
  logic [5:0] flags;
  int total = 0;
  int bad = 0;

  rsff_bank_sched #(.NREQ(4), .NFLAG(6), .IDXW(3)) dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .idx(idx), .set_all(set_all),
    .gnt(gnt), .ack(ack), .rdata(rdata), .err(err), .flags(flags), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Inputs change and outputs are sampled on rising edges; the DUT updates on falling edges.
  task automatic run_txn(input int r, input logic [1:0] o, input logic [2:0] i,
                         output logic [3:0] g, output logic a, output logic rd,
                         output logic e, output logic [5:0] f);
    @(posedge clk);
    op[2*r +: 2] = o;
    idx[3*r +: 3] = i;
    req[r] = 1'b1;
    @(posedge clk);
    g = gnt;
    @(posedge clk);
    a = ack; rd = rdata; e = err; f = flags;
    req[r] = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_reset();
    @(posedge clk);
    total++; if (gnt !== 4'b0) begin bad++; $display("FAIL reset_gnt got=%h exp=0", gnt); end
    total++; if (ack !== 1'b0 || err !== 1'b0 || rdata !== 1'b0) begin bad++; $display("FAIL reset_ack_err_rdata got=%b%b%b exp=000", ack, err, rdata); end
    total++; if (flags !== 6'h00) begin bad++; $display("FAIL reset_flags got=%h exp=00", flags); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    reset = 1'b1;
  endtask

  task automatic test_single();
    logic [3:0] g; logic a, rd, e; logic [5:0] f;
    run_txn(0, 2'b01, 3'd5, g, a, rd, e, f);
    total++; if (g !== 4'b0001) begin bad++; $display("FAIL set_gnt got=%h exp=1", g); end
    total++; if (a !== 1'b1 || rd !== 1'b0 || e !== 1'b0) begin bad++; $display("FAIL set_ack_rd_err got=%b%b%b exp=100", a, rd, e); end
    total++; if (f !== 6'h20) begin bad++; $display("FAIL set_flags got=%h exp=20", f); end
    total++; if (ack !== 1'b0 || gnt !== 4'b0 || busy !== 1'b0) begin bad++; $display("FAIL set_release got ack=%b gnt=%h busy=%b exp 0", ack, gnt, busy); end
    run_txn(0, 2'b11, 3'd5, g, a, rd, e, f);
    total++; if (a !== 1'b1 || rd !== 1'b1) begin bad++; $display("FAIL tgl_ack_rd got=%b%b exp=11", a, rd); end
    total++; if (f !== 6'h00) begin bad++; $display("FAIL tgl_flags got=%h exp=00", f); end
    run_txn(0, 2'b10, 3'd5, g, a, rd, e, f);
    total++; if (a !== 1'b1 || rd !== 1'b0) begin bad++; $display("FAIL clr_ack_rd got=%b%b exp=10", a, rd); end
    total++; if (f !== 6'h00) begin bad++; $display("FAIL clr_flags got=%h exp=00", f); end
  endtask

  task automatic test_reset_mid_done();
    @(posedge clk);
    op[3:2] = 2'b01; idx[5:3] = 3'd2; req[1] = 1'b1;
    @(posedge clk);
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL mid_gnt got=%h exp=2", gnt); end
    @(posedge clk);
    total++; if (ack !== 1'b1 || flags !== 6'h04) begin bad++; $display("FAIL mid_ack_flags got ack=%b flags=%h exp 1/04", ack, flags); end
    #2 reset = 1'b0;
    #1;
    total++; if (gnt !== 4'b0 || ack !== 1'b0) begin bad++; $display("FAIL mid_reset_gnt_ack got=%h/%b exp 0/0", gnt, ack); end
    total++; if (flags !== 6'h00 || busy !== 1'b0) begin bad++; $display("FAIL mid_reset_flags_busy got=%h/%b exp 00/0", flags, busy); end
    @(posedge clk);
    reset = 1'b1; op = '0; idx = '0; req = 4'b1111;
  endtask

  task automatic test_contention();
    int w_seq [5] = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      total++; if (gnt !== 4'(1 << w_seq[k])) begin bad++; $display("FAIL rr_gnt step=%0d got=%h exp=%h", k, gnt, 4'(1 << w_seq[k])); end
      @(posedge clk);
      total++; if (ack !== 1'b1) begin bad++; $display("FAIL rr_ack step=%0d got=%b exp=1", k, ack); end
      req[w_seq[k]] = 1'b0;
      @(posedge clk);
      if (k < 4) req[w_seq[k]] = 1'b1;
      else req = '0;
    end
    @(posedge clk);
    total++; if (busy !== 1'b0 || flags !== 6'h00) begin bad++; $display("FAIL rr_end got busy=%b flags=%h exp 0/00", busy, flags); end
  endtask

  task automatic test_set_all();
    logic [3:0] g; logic a, rd, e; logic [5:0] f;
    run_txn(2, 2'b01, 3'd3, g, a, rd, e, f);
    total++; if (g !== 4'b0100 || f !== 6'h08) begin bad++; $display("FAIL sa_pre got gnt=%h flags=%h exp 4/08", g, f); end
    @(posedge clk);
    op[5:4] = 2'b10; idx[8:6] = 3'd3; req[2] = 1'b1;
    @(posedge clk);
    set_all = 1'b1;
    @(posedge clk);
    total++; if (flags !== 6'h3f) begin bad++; $display("FAIL sa_flags got=%h exp=3f", flags); end
    total++; if (ack !== 1'b1 || rdata !== 1'b1) begin bad++; $display("FAIL sa_ack_rd got=%b%b exp=11", ack, rdata); end
    set_all = 1'b0; req[2] = 1'b0;
    @(posedge clk);
    total++; if (busy !== 1'b0 || flags !== 6'h3f) begin bad++; $display("FAIL sa_post got busy=%b flags=%h exp 0/3f", busy, flags); end
  endtask

  task automatic test_out_of_range();
    logic [3:0] g; logic a, rd, e; logic [5:0] f;
    run_txn(0, 2'b10, 3'd0, g, a, rd, e, f);
    total++; if (rd !== 1'b1 || f !== 6'h3e || e !== 1'b0) begin bad++; $display("FAIL oor_pre got rd=%b flags=%h err=%b exp 1/3e/0", rd, f, e); end
    run_txn(3, 2'b01, 3'd7, g, a, rd, e, f);
    total++; if (g !== 4'b1000 || a !== 1'b1 || e !== 1'b1) begin bad++; $display("FAIL oor_err got gnt=%h ack=%b err=%b exp 8/1/1", g, a, e); end
    total++; if (f !== 6'h3e) begin bad++; $display("FAIL oor_flags got=%h exp=3e", f); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL oor_err_clear got=%b exp=0", err); end
  endtask

  task automatic test_hold_and_ptr();
    @(posedge clk);
    op[1:0] = 2'b00; idx[2:0] = 3'd4;
    op[3:2] = 2'b11; idx[5:3] = 3'd1;
    req = 4'b0011;
    @(posedge clk);
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL ptr_wrap_gnt got=%h exp=1", gnt); end
    @(posedge clk);
    total++; if (ack !== 1'b1 || rdata !== 1'b1 || flags !== 6'h3e) begin bad++; $display("FAIL read_op got ack=%b rd=%b flags=%h exp 1/1/3e", ack, rdata, flags); end
    req[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL hold_gnt got=%h exp=2", gnt); end
    @(posedge clk);
    total++; if (ack !== 1'b1 || rdata !== 1'b1 || flags !== 6'h3c) begin bad++; $display("FAIL hold_tgl got ack=%b rd=%b flags=%h exp 1/1/3c", ack, rdata, flags); end
    repeat (5) begin
      @(posedge clk);
      total++; if (ack !== 1'b1 || gnt !== 4'b0010 || flags !== 6'h3c) begin bad++; $display("FAIL hold_steady got ack=%b gnt=%h flags=%h exp 1/2/3c", ack, gnt, flags); end
    end
    req[1] = 1'b0;
    @(posedge clk);
    total++; if (busy !== 1'b0 || gnt !== 4'b0 || ack !== 1'b0) begin bad++; $display("FAIL hold_release got busy=%b gnt=%h ack=%b exp 0/0/0", busy, gnt, ack); end
    total++; if (rdata !== 1'b1 || flags !== 6'h3c) begin bad++; $display("FAIL hold_keep got rd=%b flags=%h exp 1/3c", rdata, flags); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset_mid_done();
    test_contention();
    test_set_all();
    test_out_of_range();
    test_hold_and_ptr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
